// File: rtl/breath_led_pwm.sv
// Multi-channel breathing-LED driver: prescaled PWM whose duty follows a shared
// triangle envelope, with per-channel phase offset and off/on/breath/blink modes.
module breath_led_pwm #(
   parameter int CH_NUM     = 4,
   parameter int PWM_BITS   = 8,
   parameter int PRESCALE   = 100,
   parameter int PHASE_STEP = 128
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [7:0]          speed,
   input  logic [2*CH_NUM-1:0] mode,
   output logic [CH_NUM-1:0]   led,
   output logic                cycle_done
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int PH_W  = PWM_BITS + 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0]    pre_cnt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [7:0]          speed_cnt;
   logic [PH_W-1:0]     phase;
   logic                tick;
   logic                period_end;
   logic                step;
   logic                wrap;
   logic [CH_NUM-1:0]   led_next;

   assign tick       = (pre_cnt == PRE_LAST);
   assign period_end = tick && (pwm_cnt == '1);
   // >= rather than == so that lowering speed below the count steps at once
   assign step       = period_end && (speed_cnt >= speed);
   assign wrap       = step && (phase == '1);

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      localparam logic [PH_W-1:0] OFFSET = PH_W'(i * PHASE_STEP);
      logic [PH_W-1:0]     pos;
      logic [PWM_BITS-1:0] duty;
      logic [1:0]          ch_mode;

      assign pos     = phase + OFFSET;
      // upper half of the envelope mirrors the lower half to form the triangle
      assign duty    = pos[PWM_BITS] ? ~pos[PWM_BITS-1:0] : pos[PWM_BITS-1:0];
      assign ch_mode = mode[2*i +: 2];
      assign led_next[i] = ((ch_mode == 2'b01))
                         | ((ch_mode == 2'b10) && (pwm_cnt < duty))
                         | ((ch_mode == 2'b11) && pos[PWM_BITS]);
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         pre_cnt    <= '0;
         pwm_cnt    <= '0;
         speed_cnt  <= '0;
         phase      <= '0;
         led        <= '0;
         cycle_done <= 1'b0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
         if (tick)
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         if (period_end)
            speed_cnt <= step ? '0 : speed_cnt + 8'd1;
         if (step)
            phase <= phase + PH_W'(1);
         led        <= led_next;
         cycle_done <= wrap;
      end
   end

endmodule

// File: tb/tb_breath_led_pwm.sv
// Directed bench for breath_led_pwm with small parameters (32-clk PWM period).
module tb_breath_led_pwm;
   localparam int CH_NUM = 2, PWM_BITS = 4, PRESCALE = 2, PHASE_STEP = 16;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                en  = 1'b1;
   logic [7:0]          speed = 8'd0;
   logic [2*CH_NUM-1:0] mode = 4'b0101;
   logic [CH_NUM-1:0]   led;
   logic                cycle_done;

   int n_chk = 0, n_fail = 0, t_now = 0;

   breath_led_pwm #(
      .CH_NUM(CH_NUM), .PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE), .PHASE_STEP(PHASE_STEP)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .speed(speed), .mode(mode),
      .led(led), .cycle_done(cycle_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // After step(), led/cycle_done reflect counter state t_now-1 since enable.
   task automatic step();
      @(posedge clk);
      #1;
      t_now++;
   endtask

   task automatic restart(input logic [3:0] m, input logic [7:0] s);
      en = 1'b0;
      mode = m;
      speed = s;
      step();
      en = 1'b1;
      t_now = 0;
   endtask

   initial begin
      int bad, a0, a1, b0, b1, z0, z1, cd_n, cd_at, cd1, cd2;
      int rise0, fall0, fall1, first_hi, w0, w1, w2, w3, w4, w5, led1_c1;

      // reset with all channels on
      repeat (3) step();
      chk("rst_led", led, 0);
      chk("rst_cd", cycle_done, 0);
      rst = 1'b0;
      step();
      chk("post_rst_led", led, 3);

      // static modes
      restart(4'b0001, 8'd0);
      step();
      chk("static_led", led, 1);
      bad = 0;
      repeat (100) begin
         step();
         if (led !== 2'b01) bad++;
      end
      chk("static_hold_bad", bad, 0);

      // breath duty and cycle_done
      restart(4'b1010, 8'd0);
      a0 = 0; a1 = 0; b0 = 0; b1 = 0; z0 = 0; z1 = 0; cd_n = 0; cd_at = -1;
      for (int k = 1; k <= 1056; k++) begin
         step();
         if (t_now >= 161 && t_now <= 192) begin a0 += int'(led[0]); a1 += int'(led[1]); end
         if (t_now >= 641 && t_now <= 672) begin b0 += int'(led[0]); b1 += int'(led[1]); end
         if (t_now >= 1025 && t_now <= 1056) begin z0 += int'(led[0]); z1 += int'(led[1]); end
         if (cycle_done) begin cd_n++; cd_at = t_now; end
      end
      chk("ph5_ch0_hi", a0, 10);
      chk("ph5_ch1_hi", a1, 20);
      chk("ph20_ch0_hi", b0, 22);
      chk("ph20_ch1_hi", b1, 8);
      chk("ph0_ch0_hi", z0, 0);
      chk("ph0_ch1_hi", z1, 30);
      chk("breath_cd_count", cd_n, 1);
      chk("breath_cd_cycle", cd_at, 1024);

      // blink and phase wrap
      restart(4'b1111, 8'd0);
      rise0 = -1; fall0 = -1; fall1 = -1; cd_n = 0; cd1 = -1; cd2 = -1; led1_c1 = -1;
      for (int k = 1; k <= 2100; k++) begin
         step();
         if (t_now == 1) led1_c1 = int'(led[1]);
         if (rise0 < 0 && led[0]) rise0 = t_now;
         if (rise0 >= 0 && fall0 < 0 && !led[0]) fall0 = t_now;
         if (fall1 < 0 && !led[1]) fall1 = t_now;
         if (cycle_done) begin
            cd_n++;
            if (cd1 < 0) cd1 = t_now; else if (cd2 < 0) cd2 = t_now;
         end
      end
      chk("blink_ch0_rise", rise0, 513);
      chk("blink_ch0_fall", fall0, 1025);
      chk("blink_ch1_first", led1_c1, 1);
      chk("blink_ch1_fall", fall1, 513);
      chk("blink_cd_count", cd_n, 2);
      chk("blink_cd_first", cd1, 1024);
      chk("blink_cd_second", cd2, 2048);

      // speed divider, with live speed change 3 -> 1 while speed_cnt is 2
      restart(4'b1010, 8'd3);
      first_hi = -1; w0 = 0; w1 = 0; w2 = 0; w3 = 0; w4 = 0; w5 = 0;
      for (int k = 1; k <= 384; k++) begin
         step();
         if (t_now == 200) speed = 8'd1;
         if (first_hi < 0 && led[0]) first_hi = t_now;
         if (t_now >= 161 && t_now <= 192) w0 += int'(led[0]);
         if (t_now >= 193 && t_now <= 224) w1 += int'(led[0]);
         if (t_now >= 225 && t_now <= 256) w2 += int'(led[0]);
         if (t_now >= 257 && t_now <= 288) w3 += int'(led[0]);
         if (t_now >= 289 && t_now <= 320) w4 += int'(led[0]);
         if (t_now >= 353 && t_now <= 384) w5 += int'(led[0]);
      end
      chk("spd_first_hi", first_hi, 129);
      chk("spd_p1_a", w0, 2);
      chk("spd_p1_b", w1, 2);
      chk("spd_p2_a", w2, 4);
      chk("spd_p2_b", w3, 4);
      chk("spd_p3", w4, 6);
      chk("spd_p4", w5, 8);

      // enable drop mid-breath at phase 9
      restart(4'b1010, 8'd0);
      while (t_now < 300) step();
      en = 1'b0;
      step();
      chk("endrop_led", led, 0);
      chk("endrop_cd", cycle_done, 0);
      bad = 0;
      repeat (3) begin
         step();
         if (led !== 2'b00) bad++;
      end
      chk("endrop_hold_bad", bad, 0);
      en = 1'b1;
      t_now = 0;
      first_hi = -1; w0 = 0; led1_c1 = -1;
      for (int k = 1; k <= 64; k++) begin
         step();
         if (t_now == 1) led1_c1 = int'(led[1]);
         if (first_hi < 0 && led[0]) first_hi = t_now;
         if (t_now >= 33) w0 += int'(led[0]);
      end
      chk("reen_ch1_c1", led1_c1, 1);
      chk("reen_ch0_first_hi", first_hi, 33);
      chk("reen_ch0_ph1_hi", w0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
